lcd_rx: RTL and testbench

LCD_RX -- requirements
Module: lcd_rx

---
 rtl/lcd_pkg.sv | 77 +++++++
 rtl/lcd_strobe_sync.sv | 42 ++++
 rtl/lcd_rx.sv | 124 ++++++++++++
 tb/tb_lcd_rx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD write receiver: FSM states,
// instruction opcode masks, busy delays and DDRAM address stepping.
package lcd_pkg;

   localparam int unsigned ADDR_W  = 7;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned TIMER_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_BUSY   = 2'd2
   } state_e;

   typedef enum logic [3:0] {
      CMD_NOP,
      CMD_CLEAR,
      CMD_HOME,
      CMD_ENTRY,
      CMD_DISPLAY,
      CMD_SHIFT,
      CMD_FUNC,
      CMD_CGRAM,
      CMD_DDRAM
   } cmd_e;

   // Instruction classes are identified by their leading one bit
   localparam logic [DATA_W-1:0] MASK_DDRAM   = 8'h80, OP_DDRAM   = 8'h80;
   localparam logic [DATA_W-1:0] MASK_CGRAM   = 8'hC0, OP_CGRAM   = 8'h40;
   localparam logic [DATA_W-1:0] MASK_FUNC    = 8'hE0, OP_FUNC    = 8'h20;
   localparam logic [DATA_W-1:0] MASK_SHIFT   = 8'hF0, OP_SHIFT   = 8'h10;
   localparam logic [DATA_W-1:0] MASK_DISPLAY = 8'hF8, OP_DISPLAY = 8'h08;
   localparam logic [DATA_W-1:0] MASK_ENTRY   = 8'hFC, OP_ENTRY   = 8'h04;
   localparam logic [DATA_W-1:0] MASK_HOME    = 8'hFE, OP_HOME    = 8'h02;
   localparam logic [DATA_W-1:0] MASK_CLEAR   = 8'hFF, OP_CLEAR   = 8'h01;

   localparam logic [ADDR_W-1:0] ADDR_1L_LAST  = 7'h4F;
   localparam logic [ADDR_W-1:0] ADDR_L1_LAST  = 7'h27;
   localparam logic [ADDR_W-1:0] ADDR_L2_FIRST = 7'h40;
   localparam logic [ADDR_W-1:0] ADDR_L2_LAST  = 7'h67;

   function automatic logic [TIMER_W-1:0] delay_40us(input longint unsigned clk_freq);
      return TIMER_W'((clk_freq * 64'd40) / 64'd1000000);
   endfunction

   function automatic logic [TIMER_W-1:0] delay_1_52ms(input longint unsigned clk_freq);
      return TIMER_W'((clk_freq * 64'd152) / 64'd100000);
   endfunction

   function automatic cmd_e decode_cmd(input logic [DATA_W-1:0] dv);
      if ((dv & MASK_DDRAM) == OP_DDRAM)     return CMD_DDRAM;
      if ((dv & MASK_CGRAM) == OP_CGRAM)     return CMD_CGRAM;
      if ((dv & MASK_FUNC) == OP_FUNC)       return CMD_FUNC;
      if ((dv & MASK_SHIFT) == OP_SHIFT)     return CMD_SHIFT;
      if ((dv & MASK_DISPLAY) == OP_DISPLAY) return CMD_DISPLAY;
      if ((dv & MASK_ENTRY) == OP_ENTRY)     return CMD_ENTRY;
      if ((dv & MASK_HOME) == OP_HOME)       return CMD_HOME;
      if ((dv & MASK_CLEAR) == OP_CLEAR)     return CMD_CLEAR;
      return CMD_NOP;
   endfunction

   // Two-line mode joins 0x00..0x27 and 0x40..0x67 into one 80-cell ring
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic inc,
                                                   input logic two);
      if (inc) begin
         if (two && a == ADDR_L1_LAST) return ADDR_L2_FIRST;
         if (two && a == ADDR_L2_LAST) return '0;
         if (!two && a == ADDR_1L_LAST) return '0;
         return a + ADDR_W'(1);
      end
      if (two && a == ADDR_L2_FIRST) return ADDR_L1_LAST;
      if (a == '0) return two ? ADDR_L2_LAST : ADDR_1L_LAST;
      return a - ADDR_W'(1);
   endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Two-flop synchronizer for the LCD bus with falling-edge detect on e;
// rs/d are carried through the same stages so they align with the edge.
module lcd_strobe_sync
   import lcd_pkg::*;
(
   input  logic              clock,
   input  logic              internal_reset,
   input  logic              e,
   input  logic              rs,
   input  logic [DATA_W-1:0] d,
   output logic              fall_c,
   output logic              rs_sync,
   output logic [DATA_W-1:0] d_sync
);

   logic              e_s1, e_s2, e_s2_q;
   logic              rs_s1;
   logic [DATA_W-1:0] d_s1;

   always_ff @(posedge clock) begin
      if (internal_reset) begin
         e_s1    <= 1'b0;
         e_s2    <= 1'b0;
         e_s2_q  <= 1'b0;
         rs_s1   <= 1'b0;
         rs_sync <= 1'b0;
         d_s1    <= '0;
         d_sync  <= '0;
      end else begin
         e_s1    <= e;
         e_s2    <= e_s1;
         e_s2_q  <= e_s2;
         rs_s1   <= rs;
         rs_sync <= rs_s1;
         d_s1    <= d;
         d_sync  <= d_s1;
      end
   end

   assign fall_c = e_s2_q & ~e_s2;

endmodule

// File: rtl/lcd_rx.sv
// LCD controller write-side emulation: decodes instruction/data strobes,
// tracks the DDRAM address counter and control flags, emulates busy timing.
module lcd_rx
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100000000
) (
   input  logic              clock,
   input  logic              internal_reset,
   input  logic              rs,
   input  logic              e,
   input  logic [DATA_W-1:0] d,
   output logic              char_valid,
   output logic [ADDR_W-1:0] char_addr,
   output logic [DATA_W-1:0] char_data,
   output logic [ADDR_W-1:0] addr_counter,
   output logic              display_on,
   output logic              cursor_on,
   output logic              blink_on,
   output logic              entry_inc,
   output logic              entry_shift,
   output logic              two_line,
   output logic              busy,
   output logic              overrun
);

   localparam logic [TIMER_W-1:0] D_40US    = delay_40us(64'(CLK_FREQ));
   localparam logic [TIMER_W-1:0] D_1_52MS  = delay_1_52ms(64'(CLK_FREQ));

   logic               fall_c;
   logic               rs_sync;
   logic [DATA_W-1:0]  d_sync;
   state_e             state;
   logic [TIMER_W-1:0] timer;

   lcd_strobe_sync u_sync (
      .clock          (clock),
      .internal_reset (internal_reset),
      .e              (e),
      .rs             (rs),
      .d              (d),
      .fall_c         (fall_c),
      .rs_sync        (rs_sync),
      .d_sync         (d_sync)
   );

   // Command is applied on the edge entering DECODE so results land on the
   // third edge after e is first sampled low; busy covers exactly the delay.
   always_ff @(posedge clock) begin
      if (internal_reset) begin
         state        <= ST_IDLE;
         timer        <= '0;
         busy         <= 1'b0;
         char_valid   <= 1'b0;
         overrun      <= 1'b0;
         char_addr    <= '0;
         char_data    <= '0;
         addr_counter <= '0;
         display_on   <= 1'b0;
         cursor_on    <= 1'b0;
         blink_on     <= 1'b0;
         entry_inc    <= 1'b1;
         entry_shift  <= 1'b0;
         two_line     <= 1'b0;
      end else begin
         char_valid <= 1'b0;
         overrun    <= fall_c && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (fall_c) begin
                  state <= ST_DECODE;
                  busy  <= 1'b1;
                  timer <= D_40US;
                  if (rs_sync) begin
                     char_valid   <= 1'b1;
                     char_addr    <= addr_counter;
                     char_data    <= d_sync;
                     addr_counter <= next_addr(addr_counter, entry_inc, two_line);
                  end else begin
                     case (decode_cmd(d_sync))
                        CMD_CLEAR: begin
                           addr_counter <= '0;
                           entry_inc    <= 1'b1;
                           timer        <= D_1_52MS;
                        end
                        CMD_HOME: begin
                           addr_counter <= '0;
                           timer        <= D_1_52MS;
                        end
                        CMD_ENTRY: begin
                           entry_inc   <= d_sync[1];
                           entry_shift <= d_sync[0];
                        end
                        CMD_DISPLAY: begin
                           display_on <= d_sync[2];
                           cursor_on  <= d_sync[1];
                           blink_on   <= d_sync[0];
                        end
                        CMD_FUNC:  two_line     <= d_sync[3];
                        CMD_DDRAM: addr_counter <= d_sync[ADDR_W-1:0];
                        default: ;
                     endcase
                  end
               end
            end
            ST_DECODE: begin
               state <= ST_BUSY;
               timer <= timer - TIMER_W'(1);
            end
            ST_BUSY: begin
               if (timer <= TIMER_W'(1)) begin
                  timer <= '0;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  timer <= timer - TIMER_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_rx.sv
// Randomized bench for lcd_rx: a cycle-indexed behavioural model predicts every
// output; directed sequences pin latency, busy length and address wrap points.
module tb_lcd_rx;

   localparam int unsigned TB_CLK_FREQ = 10000000;
   localparam int D_SHORT = 400;    // 40 us at 10 MHz
   localparam int D_LONG  = 15200;  // 1.52 ms at 10 MHz

   logic       clock;
   logic       internal_reset;
   logic       rs, e;
   logic [7:0] d;
   logic       char_valid, display_on, cursor_on, blink_on;
   logic       entry_inc, entry_shift, two_line, busy, overrun;
   logic [6:0] char_addr, addr_counter;
   logic [7:0] char_data;

   lcd_rx #(.CLK_FREQ(TB_CLK_FREQ)) dut (
      .clock          (clock),
      .internal_reset (internal_reset),
      .rs             (rs),
      .e              (e),
      .d              (d),
      .char_valid     (char_valid),
      .char_addr      (char_addr),
      .char_data      (char_data),
      .addr_counter   (addr_counter),
      .display_on     (display_on),
      .cursor_on      (cursor_on),
      .blink_on       (blink_on),
      .entry_inc      (entry_inc),
      .entry_shift    (entry_shift),
      .two_line       (two_line),
      .busy           (busy),
      .overrun        (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int         t;
      bit         r;
      logic [7:0] dv;
   } ev_t;
   ev_t evq[$];

   // model state
   int m_addr = 0, m_ca = 0, m_cd = 0, m_busy_end = 0;
   bit m_inc = 1, m_shift = 0, m_disp = 0, m_cur = 0, m_blink = 0, m_two = 0;
   bit m_cv = 0, m_ov = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Address as a position on the visible ring; off-ring addresses just count
   function automatic int step_addr(input int a, input bit inc, input bit two);
      int idx;
      if (two) begin
         if (a < 40) idx = a;
         else if (a >= 64 && a < 104) idx = a - 24;
         else return inc ? (a + 1) % 128 : (a + 127) % 128;
         idx = inc ? (idx + 1) % 80 : (idx + 79) % 80;
         return (idx < 40) ? idx : idx + 24;
      end
      if (a < 80) return inc ? (a + 1) % 80 : (a + 79) % 80;
      return inc ? (a + 1) % 128 : (a + 127) % 128;
   endfunction

   task automatic model_apply(input ev_t ev);
      int dur;
      if (cyc <= m_busy_end) begin
         m_ov = 1;
         return;
      end
      dur = D_SHORT;
      if (ev.r) begin
         m_cv = 1; m_ca = m_addr; m_cd = int'(ev.dv);
         m_addr = step_addr(m_addr, m_inc, m_two);
      end else if (ev.dv[7]) m_addr = int'(ev.dv[6:0]);
      else if (ev.dv[6]) ;
      else if (ev.dv[5]) m_two = ev.dv[3];
      else if (ev.dv[4]) ;
      else if (ev.dv[3]) begin m_disp = ev.dv[2]; m_cur = ev.dv[1]; m_blink = ev.dv[0]; end
      else if (ev.dv[2]) begin m_inc = ev.dv[1]; m_shift = ev.dv[0]; end
      else if (ev.dv[1]) begin m_addr = 0; dur = D_LONG; end
      else if (ev.dv[0]) begin m_addr = 0; m_inc = 1; dur = D_LONG; end
      m_busy_end = cyc + dur;
   endtask

   // Advance the model past each rising edge and compare every output
   always begin
      @(posedge clock);
      #2;
      cyc++;
      m_cv = 0; m_ov = 0;
      if (internal_reset) begin
         m_addr = 0; m_ca = 0; m_cd = 0; m_inc = 1; m_shift = 0;
         m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0;
         m_busy_end = cyc;
         evq.delete();
      end else if (evq.size() > 0 && evq[0].t == cyc) begin
         model_apply(evq.pop_front());
      end
      check("char_valid", int'(char_valid), int'(m_cv));
      check("overrun", int'(overrun), int'(m_ov));
      check("busy", int'(busy), (cyc < m_busy_end) ? 1 : 0);
      check("addr_counter", int'(addr_counter), m_addr);
      check("char_addr", int'(char_addr), m_ca);
      check("char_data", int'(char_data), m_cd);
      check("display_on", int'(display_on), int'(m_disp));
      check("cursor_on", int'(cursor_on), int'(m_cur));
      check("blink_on", int'(blink_on), int'(m_blink));
      check("entry_inc", int'(entry_inc), int'(m_inc));
      check("entry_shift", int'(entry_shift), int'(m_shift));
      check("two_line", int'(two_line), int'(m_two));
   end

   task automatic wait_cyc(input int t);
      int guard = 0;
      while (cyc < t && guard < 40000) begin
         @(negedge clock);
         guard++;
      end
      if (cyc < t) check("wait_timeout", cyc, t);
   endtask

   task automatic wait_idle();
      wait_cyc(m_busy_end);
   endtask

   // One write strobe: e high one cycle, then low; t is the result edge
   task automatic strobe(input bit r, input logic [7:0] dv, output int t);
      ev_t ev;
      @(negedge clock);
      rs = r; d = dv; e = 1'b1;
      @(negedge clock);
      e = 1'b0;
      t = cyc + 3;
      ev.t = t; ev.r = r; ev.dv = dv;
      evq.push_back(ev);
      @(negedge clock);
   endtask

   task automatic send(input bit r, input logic [7:0] dv, output int t);
      wait_idle();
      strobe(r, dv, t);
      wait_cyc(t);
   endtask

   task automatic busy_len(input string name, input int t, input int exp);
      int n = 0;
      wait_cyc(t);
      while (busy && n < 20000) begin
         n++;
         @(negedge clock);
      end
      check(name, n, exp);
   endtask

   task automatic reset_pulse();
      internal_reset = 1'b1;
      @(negedge clock);
      internal_reset = 1'b0;
   endtask

   task automatic rand_cmd(output bit r, output logic [7:0] dv);
      int k = $urandom_range(0, 99);
      int idx;
      r = 1'b0;
      if (k < 45) begin
         r = 1'b1; dv = 8'($urandom_range(32, 126));
      end else if (k < 55) begin
         idx = $urandom_range(0, 79);
         if (m_two && idx >= 40) idx += 24;
         dv = 8'h80 | 8'(idx);
      end else if (k < 63) dv = 8'h20 | 8'($urandom_range(0, 31));
      else if (k < 73) dv = 8'h08 | 8'($urandom_range(0, 7));
      else if (k < 83) dv = 8'h04 | 8'($urandom_range(0, 3));
      else if (k < 88) dv = 8'h10 | 8'($urandom_range(0, 15));
      else if (k < 93) dv = 8'h40 | 8'($urandom_range(0, 63));
      else dv = 8'h00;
   endtask

   initial begin
      int t, t1, t2, target, k;
      bit r;
      logic [7:0] dv;

      internal_reset = 1'b1; e = 1'b0; rs = 1'b0; d = 8'h00;
      repeat (3) @(negedge clock);
      internal_reset = 1'b0;
      check("rst_busy", int'(busy), 0);
      check("rst_entry_inc", int'(entry_inc), 1);
      check("rst_addr", int'(addr_counter), 0);
      check("pkg_d40_100mhz", int'(lcd_pkg::delay_40us(64'd100000000)), 4000);
      check("pkg_d152_100mhz", int'(lcd_pkg::delay_1_52ms(64'd100000000)), 152000);

      // data write latency and result
      strobe(1'b1, 8'h48, t);
      wait_cyc(t - 1);
      check("lat_early_cv", int'(char_valid), 0);
      wait_cyc(t);
      check("lat_cv", int'(char_valid), 1);
      check("lat_char_addr", int'(char_addr), 0);
      check("lat_char_data", int'(char_data), 8'h48);
      check("lat_addr", int'(addr_counter), 1);
      wait_cyc(t + 1);
      check("lat_cv_pulse", int'(char_valid), 0);

      // function set and display control, each busy for 40 us
      wait_idle();
      strobe(1'b0, 8'h38, t);
      busy_len("busy_len_38", t, D_SHORT);
      check("func_two_line", int'(two_line), 1);
      wait_idle();
      strobe(1'b0, 8'h0C, t);
      busy_len("busy_len_0c", t, D_SHORT);
      check("disp_on", int'(display_on), 1);
      check("disp_cursor", int'(cursor_on), 0);

      // two-line wrap points in both directions
      send(1'b0, 8'hA7, t);
      send(1'b1, 8'h41, t);
      check("wrap_27_40", int'(addr_counter), 8'h40);
      send(1'b0, 8'hE7, t);
      send(1'b1, 8'h42, t);
      check("wrap_67_00", int'(addr_counter), 0);
      send(1'b0, 8'h04, t);
      send(1'b1, 8'h43, t);
      check("wrap_dec_addr", int'(char_addr), 0);
      check("wrap_00_67", int'(addr_counter), 8'h67);

      // clear, then a strobe while busy is discarded
      send(1'b0, 8'h01, t1);
      check("clr_addr", int'(addr_counter), 0);
      check("clr_inc", int'(entry_inc), 1);
      wait_cyc(t1 + 996);
      strobe(1'b1, 8'h55, t2);
      wait_cyc(t2);
      check("ovr_pulse", int'(overrun), 1);
      check("ovr_no_cv", int'(char_valid), 0);
      check("ovr_addr", int'(addr_counter), 0);
      wait_cyc(t1 + D_LONG - 1);
      check("clr_busy_last", int'(busy), 1);
      wait_cyc(t1 + D_LONG);
      check("clr_busy_done", int'(busy), 0);

      // reset in the middle of a clear
      send(1'b0, 8'h05, t);
      send(1'b0, 8'h01, t);
      wait_cyc(t + 500);
      check("mid_busy", int'(busy), 1);
      reset_pulse();
      check("mr_busy", int'(busy), 0);
      check("mr_shift", int'(entry_shift), 0);
      check("mr_two_line", int'(two_line), 0);
      check("mr_display", int'(display_on), 0);
      check("mr_char_data", int'(char_data), 0);
      repeat (20) @(negedge clock);

      // reset one edge before, and on, the decode edge of a pending strobe
      for (int off = 1; off <= 2; off++) begin
         wait_idle();
         strobe(1'b1, 8'h61, t);
         if (off == 2) @(negedge clock);
         reset_pulse();
         wait_cyc(t + 3);
         check("pipe_rst_addr", int'(addr_counter), 0);
         check("pipe_rst_data", int'(char_data), 0);
      end

      // return home uses the long delay
      send(1'b0, 8'h85, t);
      send(1'b0, 8'h03, t);
      check("home_addr", int'(addr_counter), 0);
      wait_cyc(t + 500);
      check("home_busy", int'(busy), 1);
      reset_pulse();

      // random traffic, with strobes aimed around busy expiry
      t = cyc;
      for (int i = 0; i < 100; i++) begin
         wait_cyc(t);
         rand_cmd(r, dv);
         k = $urandom_range(0, 9);
         if (k < 5) target = m_busy_end + 1 + $urandom_range(0, 4);
         else if (k < 8) target = m_busy_end - 1 + $urandom_range(0, 1);
         else target = cyc + 5 + $urandom_range(0, 30);
         wait_cyc(target - 5);
         strobe(r, dv, t);
      end
      wait_cyc(t);
      wait_cyc(m_busy_end + 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
